// File: rtl/word_order_stream_controller.sv
//------------------------------------------------------------------------------
// Module      : word_order_stream_controller
// Description : Packet-aware byte/bit-order converter with valid/ready
//               handshakes on both sides. One reordering mode is selected
//               per packet (0 pass, 1 word reverse, 2 bit reverse within each
//               word, 3 full bit reverse). The mode register can only be
//               updated between packets. The transform is applied when a
//               beat is captured, and the beat then goes into a 2-entry skid
//               buffer whose main register drives the output.
// Ports       : clock, reset_n (async active-low)
//               config_mode/config_valid/config_ready - mode update handshake
//               input_data/input_last/input_valid/input_ready - upstream beats
//               output_data/output_last/output_valid/output_ready - downstream
//               busy - packet in progress or beats buffered
//               packet_beats[15:0] - only with WORD_ORDER_STREAM_BEAT_COUNT_EN
// Options     : `define WORD_ORDER_STREAM_BEAT_COUNT_EN adds the saturating
//               per-packet beat counter and its packet_beats output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module word_order_stream_controller #(
  parameter  int WORD_WIDTH  = 8,
  parameter  int WORD_COUNT  = 4,
  localparam int TOTAL_WIDTH = WORD_WIDTH * WORD_COUNT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [1:0]             config_mode,
  input  logic                   config_valid,
  output logic                   config_ready,
  input  logic [TOTAL_WIDTH-1:0] input_data,
  input  logic                   input_last,
  input  logic                   input_valid,
  output logic                   input_ready,
  output logic [TOTAL_WIDTH-1:0] output_data,
  output logic                   output_last,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic                   busy
`ifdef WORD_ORDER_STREAM_BEAT_COUNT_EN
  ,
  output logic [15:0]            packet_beats
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_PACKET = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [1:0]             r_mode;

  logic                   r_out_valid;
  logic [TOTAL_WIDTH-1:0] r_out_data;
  logic                   r_out_last;
  logic                   r_skid_valid;
  logic [TOTAL_WIDTH-1:0] r_skid_data;
  logic                   r_skid_last;

  logic [TOTAL_WIDTH-1:0] w_rev_word;
  logic [TOTAL_WIDTH-1:0] w_rev_bits;
  logic [TOTAL_WIDTH-1:0] w_rev_full;
  logic [TOTAL_WIDTH-1:0] w_xform;
  logic                   w_push;
  logic                   w_pop;

  // Reordering networks: pure wiring, one selected by the mode register.
  for (genvar w = 0; w < WORD_COUNT; w++) begin : g_word
    assign w_rev_word[(WORD_COUNT-1-w)*WORD_WIDTH +: WORD_WIDTH] =
      input_data[w*WORD_WIDTH +: WORD_WIDTH];
    for (genvar b = 0; b < WORD_WIDTH; b++) begin : g_bit
      assign w_rev_bits[w*WORD_WIDTH + WORD_WIDTH-1-b] = input_data[w*WORD_WIDTH + b];
    end
  end

  for (genvar k = 0; k < TOTAL_WIDTH; k++) begin : g_full
    assign w_rev_full[TOTAL_WIDTH-1-k] = input_data[k];
  end

  always_comb begin
    w_xform = input_data;
    case (r_mode)
      2'd1:    w_xform = w_rev_word;
      2'd2:    w_xform = w_rev_bits;
      2'd3:    w_xform = w_rev_full;
      default: w_xform = input_data;
    endcase
  end

  // FSM: the base ready term is the skid register (registered occupancy);
  // the only combinational term is IDLE config priority.
  always_comb begin
    w_next_state = r_state;
    config_ready = 1'b0;
    input_ready  = ~r_skid_valid;
    case (r_state)
      ST_IDLE: begin
        config_ready = 1'b1;
        if (config_valid) begin
          input_ready = 1'b0;
        end
        if (input_valid && !r_skid_valid && !config_valid && !input_last) begin
          w_next_state = ST_PACKET;
        end
      end
      ST_PACKET: begin
        if (input_valid && !r_skid_valid && input_last) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_push = input_valid & input_ready;
  assign w_pop  = r_out_valid & output_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_mode  <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if (config_valid && config_ready) begin
        r_mode <= config_mode;
      end
    end
  end

  // Skid buffer. The skid entry is only filled when the main register is
  // occupied and not draining; it refills the main register on the next pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
    end else if (r_skid_valid) begin
      if (w_pop) begin
        r_out_data   <= r_skid_data;
        r_out_last   <= r_skid_last;
        r_skid_valid <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_out_valid || w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_xform;
        r_out_last  <= input_last;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_xform;
        r_skid_last  <= input_last;
      end
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign output_valid = r_out_valid;
  assign output_data  = r_out_data;
  assign output_last  = r_out_last;
  assign busy         = (r_state == ST_PACKET) | r_out_valid | r_skid_valid;

`ifdef WORD_ORDER_STREAM_BEAT_COUNT_EN
  logic [15:0] r_beat_cnt;
  logic [15:0] r_packet_beats;
  logic [15:0] w_cnt_inc;

  assign w_cnt_inc = (r_beat_cnt == 16'hFFFF) ? 16'hFFFF : r_beat_cnt + 16'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_cnt     <= 16'd0;
      r_packet_beats <= 16'd0;
    end else if (w_push) begin
      if (input_last) begin
        r_packet_beats <= w_cnt_inc;
        r_beat_cnt     <= 16'd0;
      end else begin
        r_beat_cnt <= w_cnt_inc;
      end
    end
  end

  assign packet_beats = r_packet_beats;
`endif

endmodule

`default_nettype wire

// File: tb/tb_word_order_stream_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_word_order_stream_controller
// Description : Self-checking bench for word_order_stream_controller with a
//               queue scoreboard: expected beats are pushed on input
//               handshakes and compared when the output handshakes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_word_order_stream_controller;

  logic        clock;
  logic        reset_n;
  logic [1:0]  config_mode;
  logic        config_valid;
  logic        config_ready;
  logic [31:0] input_data;
  logic        input_last;
  logic        input_valid;
  logic        input_ready;
  logic [31:0] output_data;
  logic        output_last;
  logic        output_valid;
  logic        output_ready;
  logic        busy;
`ifdef WORD_ORDER_STREAM_BEAT_COUNT_EN
  logic [15:0] packet_beats;
`endif

  word_order_stream_controller #(
    .WORD_WIDTH(8),
    .WORD_COUNT(4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .config_mode  (config_mode),
    .config_valid (config_valid),
    .config_ready (config_ready),
    .input_data   (input_data),
    .input_last   (input_last),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_last  (output_last),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .busy         (busy)
`ifdef WORD_ORDER_STREAM_BEAT_COUNT_EN
    ,
    .packet_beats (packet_beats)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [1:0]  model_mode = 2'd0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (m)
      2'd1: r = {d[7:0], d[15:8], d[23:16], d[31:24]};
      2'd2: for (int k = 0; k < 32; k++) r[(k/8)*8 + 7 - (k%8)] = d[k];
      2'd3: for (int k = 0; k < 32; k++) r[31-k] = d[k];
      default: r = d;
    endcase
    return r;
  endfunction

  // Output monitor: a transfer happens at the next rising edge.
  always @(negedge clock) begin
    if (reset_n && output_valid && output_ready) begin
      if (sb.size() == 0) begin
        check_value("unexpected_output", 64'(output_data), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_value("out_data", 64'(output_data), 64'(e.data));
        check_value("out_last", 64'(output_last), 64'(e.last));
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l, input logic [31:0] exp_d);
    bit ok;
    ok = 1'b0;
    input_data  = d;
    input_last  = l;
    input_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (input_ready) begin
        sb.push_back('{data: exp_d, last: l});
        ok = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    input_valid = 1'b0;
    if (!ok) check_value("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_config(input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    config_mode  = m;
    config_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (config_ready) ok = 1'b1;
      @(posedge clock);
      #1;
    end
    config_valid = 1'b0;
    model_mode   = m;
    if (!ok) check_value("config_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clock);
    #1;
    check_value("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [31:0] bp_data[5];
  logic [31:0] hold_data;
  int          idx;
  logic [31:0] d;

  initial begin
    reset_n      = 1'b0;
    config_mode  = 2'd0;
    config_valid = 1'b0;
    input_data   = '0;
    input_last   = 1'b0;
    input_valid  = 1'b0;
    output_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_value("rst_out_valid", 64'(output_valid), 64'd0);
    check_value("rst_out_data",  64'(output_data),  64'd0);
    check_value("rst_out_last",  64'(output_last),  64'd0);
    check_value("rst_busy",      64'(busy),         64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_value("rst_cfg_ready", 64'(config_ready), 64'd1);
    check_value("rst_in_ready",  64'(input_ready),  64'd1);

    // Mode 0 single beat, one-cycle latency
    do_config(2'd0);
    check_value("lat_before", 64'(output_valid), 64'd0);
    send_beat(32'h11223344, 1'b1, 32'h11223344);
    check_value("lat_valid_n1", 64'(output_valid), 64'd1);
    @(posedge clock);
    #1;
    check_value("lat_gone_n2", 64'(output_valid), 64'd0);

    // Mode 1, three-beat packet
    do_config(2'd1);
    send_beat(32'h11223344, 1'b0, 32'h44332211);
    check_value("pkt_busy", 64'(busy), 64'd1);
    send_beat(32'hAABBCCDD, 1'b0, 32'hDDCCBBAA);
    send_beat(32'h01020304, 1'b1, 32'h04030201);
    drain();
`ifdef WORD_ORDER_STREAM_BEAT_COUNT_EN
    check_value("packet_beats", 64'(packet_beats), 64'd3);
`endif

    // Modes 2 and 3
    do_config(2'd2);
    send_beat(32'h01020304, 1'b1, 32'h8040C020);
    do_config(2'd3);
    send_beat(32'h00000001, 1'b1, 32'h80000000);
    drain();

    // Config held during a mode-1 packet
    do_config(2'd1);
    send_beat(32'hA5A5_0F0F, 1'b0, model(2'd1, 32'hA5A5_0F0F));
    config_mode  = 2'd3;
    config_valid = 1'b1;
    @(negedge clock);
    check_value("cfg_blocked", 64'(config_ready), 64'd0);
    @(posedge clock);
    #1;
    send_beat(32'h1234_5678, 1'b0, model(2'd1, 32'h1234_5678));
    check_value("cfg_blocked2", 64'(config_ready), 64'd0);
    send_beat(32'hCAFE_BABE, 1'b1, model(2'd1, 32'hCAFE_BABE));
    check_value("cfg_ready_after_last", 64'(config_ready), 64'd1);
    check_value("cfg_priority_in_ready", 64'(input_ready), 64'd0);
    @(posedge clock);
    #1;
    config_valid = 1'b0;
    model_mode   = 2'd3;
    send_beat(32'h0000_00F1, 1'b1, 32'h8F00_0000);
    drain();

    // Backpressure: 5 stall cycles with input always offered
    for (int i = 0; i < 5; i++) bp_data[i] = $urandom;
    idx       = 0;
    hold_data = '0;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      output_ready = (cyc >= 5);
      input_valid  = 1'b1;
      input_data   = bp_data[idx];
      input_last   = (idx == 4);
      @(negedge clock);
      if (cyc == 1) hold_data = output_data;
      if (cyc >= 2 && cyc < 5) begin
        check_value("bp_hold_data", 64'(output_data), 64'(hold_data));
        check_value("bp_in_ready",  64'(input_ready), 64'd0);
      end
      if (input_ready) begin
        sb.push_back('{data: model(model_mode, bp_data[idx]), last: (idx == 4)});
        idx++;
      end
      if (cyc == 4) check_value("bp_accepted", 64'(idx), 64'd2);
      @(posedge clock);
      #1;
    end
    input_valid  = 1'b0;
    output_ready = 1'b1;
    check_value("bp_all_sent", 64'(idx), 64'd5);
    drain();

    // Reset mid-packet with two beats buffered
    do_config(2'd2);
    output_ready = 1'b0;
    d = $urandom;
    send_beat(d, 1'b0, model(2'd2, d));
    d = $urandom;
    send_beat(d, 1'b0, model(2'd2, d));
    check_value("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("mid_rst_valid", 64'(output_valid), 64'd0);
    check_value("mid_rst_busy",  64'(busy),         64'd0);
    sb.delete();
    model_mode = 2'd0;
    @(negedge clock);
    @(negedge clock);
    reset_n      = 1'b1;
    output_ready = 1'b1;
    @(posedge clock);
    #1;
    check_value("post_rst_idle", 64'(config_ready), 64'd1);
    send_beat(32'h01020304, 1'b1, 32'h01020304);
    drain();
    @(posedge clock);
    #1;
    check_value("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
